// File: rtl/power_seq_ctrl.sv
// Power sequencer: gates the CPU clock and drives low-power hooks through RUN/DRAIN/SLEEP/WAKE.
// Optional self-wake from SLEEP after AUTOWAKE_CYCLES is built when POWER_SEQ_AUTOWAKE_EN is defined.
module power_seq_ctrl #(
    parameter int unsigned SLEEP_DELAY     = 4,
    parameter int unsigned WAKE_SETTLE     = 16,
    parameter int unsigned AUTOWAKE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wfi,
    input  logic        data_clk_stall,
    input  logic        wake_evt,
    output logic        proc_clk_en,
    output logic        mem_sleep,
    output logic        osc_lowpower,
    output logic        wake_ack,
    output logic [1:0]  state,
    output logic [15:0] sleep_cycles
);

    localparam int unsigned CNT_MAX = (SLEEP_DELAY > WAKE_SETTLE) ? SLEEP_DELAY : WAKE_SETTLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned SLP_W   = 16;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SLEEP = 2'd2;
    localparam logic [1:0] ST_WAKE  = 2'd3;

    if (SLEEP_DELAY < 1 || WAKE_SETTLE < 1 || AUTOWAKE_CYCLES < 1) begin : g_param_check
        $error("power_seq_ctrl: SLEEP_DELAY, WAKE_SETTLE and AUTOWAKE_CYCLES must be >= 1");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SLP_W-1:0] slp_q, slp_d;
    logic             wake_ack_q, wake_ack_d;
    logic             lowpwr_q;
    logic             autowake_c;

`ifdef POWER_SEQ_AUTOWAKE_EN
    assign autowake_c = (slp_q == SLP_W'(AUTOWAKE_CYCLES - 1));
`else
    assign autowake_c = 1'b0;
`endif

    // Next-state: shared down-counter times both DRAIN and WAKE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        slp_d      = slp_q;
        wake_ack_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A wfi still high in the wake_ack cycle is stale and must not re-enter sleep
                if (wfi && !wake_evt && !wake_ack_q) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(SLEEP_DELAY - 1);
                end
            end
            ST_DRAIN: begin
                if (wake_evt) begin
                    state_d = ST_RUN;
                end else if (data_clk_stall) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == '0) begin
                    state_d = ST_SLEEP;
                    slp_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SLEEP: begin
                if (wake_evt || autowake_c) begin
                    state_d = ST_WAKE;
                    cnt_d   = CNT_W'(WAKE_SETTLE - 1);
                end else if (slp_q != {SLP_W{1'b1}}) begin
                    slp_d = slp_q + SLP_W'(1);
                end
            end
            ST_WAKE: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RUN;
                    wake_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            slp_q      <= '0;
            wake_ack_q <= 1'b0;
            lowpwr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slp_q      <= slp_d;
            wake_ack_q <= wake_ack_d;
            lowpwr_q   <= (state_d == ST_SLEEP);
        end
    end

    // Stall gating is combinational so the CPU freezes in the same cycle
    assign proc_clk_en  = (state_q == ST_RUN) & ~data_clk_stall & ~rst;
    assign mem_sleep    = lowpwr_q;
    assign osc_lowpower = lowpwr_q;
    assign wake_ack     = wake_ack_q;
    assign state        = state_q;
    assign sleep_cycles = slp_q;

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Randomized and directed bench for power_seq_ctrl against a phase-level reference model.
module tb_power_seq_ctrl;

    localparam int SD = 4;
    localparam int WS = 16;
    localparam int AW = 20;

    localparam int P_RUN   = 0;
    localparam int P_DRAIN = 1;
    localparam int P_SLEEP = 2;
    localparam int P_WAKE  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wfi;
    logic        data_clk_stall;
    logic        wake_evt;
    logic        proc_clk_en;
    logic        mem_sleep;
    logic        osc_lowpower;
    logic        wake_ack;
    logic [1:0]  state;
    logic [15:0] sleep_cycles;

    int total = 0;
    int bad   = 0;

    // Reference model: phase plus elapsed-cycle counts
    int m_phase;
    int m_drained;
    int m_settled;
    int m_slept;
    bit m_ack;

    power_seq_ctrl #(
        .SLEEP_DELAY    (SD),
        .WAKE_SETTLE    (WS),
        .AUTOWAKE_CYCLES(AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wfi           (wfi),
        .data_clk_stall(data_clk_stall),
        .wake_evt      (wake_evt),
        .proc_clk_en   (proc_clk_en),
        .mem_sleep     (mem_sleep),
        .osc_lowpower  (osc_lowpower),
        .wake_ack      (wake_ack),
        .state         (state),
        .sleep_cycles  (sleep_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_RUN;
        m_drained = 0;
        m_settled = 0;
        m_slept   = 0;
        m_ack     = 1'b0;
    endtask

    task automatic model_step(input bit w, input bit s, input bit e);
        bit ack_next;
        bit aw;
        ack_next = 1'b0;
`ifdef POWER_SEQ_AUTOWAKE_EN
        aw = (m_slept == AW - 1);
`else
        aw = 1'b0;
`endif
        case (m_phase)
            P_RUN: if (w && !e && !m_ack) begin
                m_phase   = P_DRAIN;
                m_drained = 0;
            end
            P_DRAIN: begin
                if (e) m_phase = P_RUN;
                else if (!s) begin
                    if (m_drained + 1 == SD) begin
                        m_phase = P_SLEEP;
                        m_slept = 0;
                    end else m_drained++;
                end
            end
            P_SLEEP: begin
                if (e || aw) begin
                    m_phase   = P_WAKE;
                    m_settled = 0;
                end else if (m_slept < 65535) m_slept++;
            end
            default: begin
                m_settled++;
                if (m_settled == WS) begin
                    m_phase  = P_RUN;
                    ack_next = 1'b1;
                end
            end
        endcase
        m_ack = ack_next;
    endtask

    task automatic check_regs();
        check_eq("state", 32'(state), m_phase);
        check_eq("mem_sleep", 32'(mem_sleep), int'(m_phase == P_SLEEP));
        check_eq("osc_lowpower", 32'(osc_lowpower), int'(m_phase == P_SLEEP));
        check_eq("wake_ack", 32'(wake_ack), int'(m_ack));
        check_eq("sleep_cycles", 32'(sleep_cycles), m_slept);
    endtask

    // Apply inputs, check the combinational enable, clock once, check registered outputs
    task automatic step(input bit w, input bit s, input bit e);
        wfi = w;
        data_clk_stall = s;
        wake_evt = e;
        #1;
        check_eq("proc_clk_en", 32'(proc_clk_en), int'(m_phase == P_RUN && !s));
        @(posedge clk);
        model_step(w, s, e);
        #1;
        check_regs();
    endtask

    task automatic wait_state(input string tag, input int target, input bit w, input int budget);
        int n;
        n = 0;
        while (32'(state) != 32'(target) && n < budget) begin
            step(w, 1'b0, 1'b0);
            n++;
        end
        check_eq(tag, 32'(state), target);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        wfi = 1'b0;
        data_clk_stall = 1'b0;
        wake_evt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_clk_en", 32'(proc_clk_en), 0);
        check_regs();
        rst = 1'b0;

        // Stall gating in RUN
        step(0, 0, 0);
        repeat (3) step(0, 1, 0);
        step(0, 0, 0);

        // wfi -> DRAIN for SD cycles -> SLEEP, 50 sleep cycles, wake
        step(1, 0, 0);
        check_eq("enter_drain", 32'(state), P_DRAIN);
        repeat (SD - 1) step(1, 0, 0);
        check_eq("still_drain", 32'(state), P_DRAIN);
        step(1, 0, 0);
        check_eq("enter_sleep", 32'(state), P_SLEEP);
        repeat (50) step(1, 0, 0);
        step(1, 0, 1);
        check_eq("slp_held", 32'(sleep_cycles), 50);
        check_eq("enter_wake", 32'(state), P_WAKE);
        repeat (WS - 1) step(1, 0, 0);
        check_eq("wake_last", 32'(state), P_WAKE);
        step(1, 0, 0);
        check_eq("ack_pulse", 32'(wake_ack), 1);
        step(1, 0, 0);
        check_eq("stale_wfi", 32'(state), P_RUN);
        step(0, 0, 0);

        // Drain stretched by 6 stall cycles
        cnt = 0;
        step(1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            if (state == 2'(P_DRAIN)) cnt++;
            step(1, 1, 0);
        end
        while (state == 2'(P_DRAIN) && cnt < 40) begin
            cnt++;
            step(1, 0, 0);
        end
        check_eq("drain_len", 32'(cnt), SD + 6);
        step(0, 0, 1);
        wait_state("wake_to_run", P_RUN, 1'b0, 40);
        step(0, 0, 0);

        // wake_evt during DRAIN aborts without ack
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        check_eq("drain_abort", 32'(state), P_RUN);
        check_eq("drain_no_ack", 32'(wake_ack), 0);
        step(0, 0, 0);

        // wfi and wake_evt together in RUN
        step(1, 0, 1);
        check_eq("wake_wins", 32'(state), P_RUN);
        step(0, 0, 0);

        // Async reset in the middle of SLEEP
        step(1, 0, 0);
        wait_state("reach_sleep", P_SLEEP, 1'b1, 20);
        repeat (7) step(1, 0, 0);
        rst = 1'b1;
        wfi = 1'b0;
        #1;
        check_eq("arst_state", 32'(state), P_RUN);
        check_eq("arst_slp", 32'(sleep_cycles), 0);
        check_eq("arst_mem", 32'(mem_sleep), 0);
        check_eq("arst_en", 32'(proc_clk_en), 0);
        model_reset();
        #2;
        rst = 1'b0;
        step(0, 0, 0);

        // Self-wake versus indefinite sleep
        step(1, 0, 0);
        wait_state("reach_sleep2", P_SLEEP, 1'b1, 20);
`ifdef POWER_SEQ_AUTOWAKE_EN
        cnt = 0;
        while (state == 2'(P_SLEEP) && cnt < 200) begin
            step(0, 0, 0);
            cnt++;
        end
        check_eq("autowake_state", 32'(state), P_WAKE);
        check_eq("autowake_slp", 32'(sleep_cycles), AW - 1);
`else
        repeat (5000) step(0, 0, 0);
        check_eq("sleep_hold", 32'(state), P_SLEEP);
        step(0, 0, 1);
`endif
        wait_state("wake_to_run2", P_RUN, 1'b0, 40);
        step(0, 0, 0);

        // Random traffic
        repeat (3000) begin
            step(bit'($urandom_range(0, 99) < 60),
                 bit'($urandom_range(0, 99) < 25),
                 bit'($urandom_range(0, 99) < 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
